// File: rtl/usb_tx_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_scheduler_if
// Purpose  : Groups the signals of the USB TX scheduler into one bundle:
//            requester handshakes, the USB_TX command/status link, and the
//            scheduler status outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface usb_tx_scheduler_if;
  // Handshake responder requester
  logic       hs_req;
  logic [1:0] hs_pid;
  logic       hs_grant;
  // Endpoint data path requester
  logic       data_req;
  logic [6:0] data_len;
  logic       data_grant;
  logic       toggle_reset;
  // USB_TX link
  logic [6:0] Buffer_Occupancy;
  logic [3:0] TX_Packet;
  logic       TX_Transfer_Active;
  logic       TX_Error;
  // Status
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic       data_toggle;

  // Scheduler side
  modport slave (
    input  hs_req, hs_pid, data_req, data_len, toggle_reset,
           Buffer_Occupancy, TX_Transfer_Active, TX_Error,
    output hs_grant, data_grant, TX_Packet, busy, done, err, err_code,
           data_toggle
  );

  // Requester / transmitter side
  modport master (
    output hs_req, hs_pid, data_req, data_len, toggle_reset,
           Buffer_Occupancy, TX_Transfer_Active, TX_Error,
    input  hs_grant, data_grant, TX_Packet, busy, done, err, err_code,
           data_toggle
  );
endinterface
`default_nettype wire

// File: rtl/usb_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_scheduler
// Purpose  : Arbitrates the single USB_TX command port between the handshake
//            responder and the endpoint data path, waits for the TX FIFO to
//            hold the payload, tracks DATA0/DATA1, supervises the transfer
//            and enforces an inter-packet gap. All outputs are registered.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_scheduler #(
  parameter int IPG_CYCLES    = 16,
  parameter int START_TIMEOUT = 8,
  parameter int FILL_TIMEOUT  = 255,
  parameter int MAX_LEN       = 64
) (
  input  wire logic          clk,
  input  wire logic          n_rst,
  usb_tx_scheduler_if.slave  bus
);

  // Packet command codes presented on TX_Packet
  localparam logic [3:0] PKT_NONE  = 4'b0000;
  localparam logic [3:0] PKT_ACK   = 4'b0010;
  localparam logic [3:0] PKT_NAK   = 4'b1010;
  localparam logic [3:0] PKT_STALL = 4'b1110;
  localparam logic [3:0] PKT_DATA0 = 4'b0011;
  localparam logic [3:0] PKT_DATA1 = 4'b1011;

  // Error codes
  localparam logic [1:0] ERR_TX     = 2'b00;
  localparam logic [1:0] ERR_LEN    = 2'b01;
  localparam logic [1:0] ERR_FILL   = 2'b10;
  localparam logic [1:0] ERR_START  = 2'b11;

  // One shared cycle counter, sized for the longest interval it must time
  localparam int CNT_MAX_A = (IPG_CYCLES > START_TIMEOUT) ? IPG_CYCLES : START_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > FILL_TIMEOUT) ? CNT_MAX_A : FILL_TIMEOUT;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_SAT    = '1;
  localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(IPG_CYCLES - 1);
  localparam logic [6:0]       LEN_LIMIT  = 7'(MAX_LEN);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_DATA  = 3'd1,
    ISSUE      = 3'd2,
    WAIT_START = 3'd3,
    ACTIVE     = 3'd4,
    GAP        = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [6:0]       len_q, len_nx;
  logic             is_data_q, is_data_nx;   // granted request is a data packet
  logic             bad_q, bad_nx;           // granted request was rejected
  logic             txerr_q, txerr_nx;       // sticky TX_Error seen in ACTIVE

  logic [3:0]       tx_q, tx_nx;
  logic             hs_grant_q, hs_grant_nx;
  logic             data_grant_q, data_grant_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;
  logic             err_q, err_nx;
  logic [1:0]       err_code_q, err_code_nx;
  logic             toggle_q, toggle_nx;
  logic             flip;
  logic             active_err;

  // Handshake PID to command code; 11 never reaches here (rejected earlier)
  function automatic logic [3:0] hs_code(input logic [1:0] pid);
    case (pid)
      2'b00:   hs_code = PKT_ACK;
      2'b01:   hs_code = PKT_NAK;
      default: hs_code = PKT_STALL;
    endcase
  endfunction

  // State, bookkeeping and registered outputs
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      len_q        <= '0;
      is_data_q    <= 1'b0;
      bad_q        <= 1'b0;
      txerr_q      <= 1'b0;
      tx_q         <= PKT_NONE;
      hs_grant_q   <= 1'b0;
      data_grant_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'b00;
      toggle_q     <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      len_q        <= len_nx;
      is_data_q    <= is_data_nx;
      bad_q        <= bad_nx;
      txerr_q      <= txerr_nx;
      tx_q         <= tx_nx;
      hs_grant_q   <= hs_grant_nx;
      data_grant_q <= data_grant_nx;
      busy_q       <= busy_nx;
      done_q       <= done_nx;
      err_q        <= err_nx;
      err_code_q   <= err_code_nx;
      toggle_q     <= toggle_nx;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_nx      = state;
    len_nx        = len_q;
    is_data_nx    = is_data_q;
    bad_nx        = bad_q;
    txerr_nx      = txerr_q;
    tx_nx         = PKT_NONE;
    hs_grant_nx   = 1'b0;
    data_grant_nx = 1'b0;
    done_nx       = 1'b0;
    err_nx        = 1'b0;
    err_code_nx   = err_code_q;
    flip          = 1'b0;
    active_err    = txerr_q | bus.TX_Error;

    case (state)
      IDLE: begin
        if (bus.hs_req) begin
          state_nx    = ISSUE;
          hs_grant_nx = 1'b1;
          is_data_nx  = 1'b0;
          if (bus.hs_pid == 2'b11) begin
            bad_nx      = 1'b1;
            err_nx      = 1'b1;
            err_code_nx = ERR_LEN;
          end else begin
            bad_nx = 1'b0;
            tx_nx  = hs_code(bus.hs_pid);
          end
        end else if (bus.data_req) begin
          state_nx      = WAIT_DATA;
          data_grant_nx = 1'b1;
          is_data_nx    = 1'b1;
          len_nx        = bus.data_len;
          if (bus.data_len > LEN_LIMIT) begin
            bad_nx      = 1'b1;
            err_nx      = 1'b1;
            err_code_nx = ERR_LEN;
          end else begin
            bad_nx = 1'b0;
          end
        end
      end

      WAIT_DATA: begin
        if (bad_q) begin
          state_nx = IDLE;
        end else if (bus.Buffer_Occupancy >= len_q) begin
          state_nx = ISSUE;
          tx_nx    = toggle_q ? PKT_DATA1 : PKT_DATA0;
        end else if (cnt >= FILL_LAST) begin
          state_nx    = IDLE;
          err_nx      = 1'b1;
          err_code_nx = ERR_FILL;
        end
      end

      ISSUE: begin
        // The command itself was driven on entry; this cycle is its slot.
        txerr_nx = 1'b0;
        state_nx = bad_q ? IDLE : WAIT_START;
      end

      WAIT_START: begin
        if (bus.TX_Transfer_Active) begin
          state_nx = ACTIVE;
        end else if (cnt >= START_LAST) begin
          state_nx    = GAP;
          err_nx      = 1'b1;
          err_code_nx = ERR_START;
        end
      end

      ACTIVE: begin
        txerr_nx = active_err;
        if (!bus.TX_Transfer_Active) begin
          state_nx = GAP;
          if (active_err) begin
            err_nx      = 1'b1;
            err_code_nx = ERR_TX;
          end else begin
            done_nx = 1'b1;
            flip    = is_data_q;
          end
        end
      end

      GAP: begin
        if (cnt >= GAP_LAST) state_nx = IDLE;
      end

      default: state_nx = IDLE;
    endcase

    // Counter restarts on every state change and saturates otherwise
    if (state_nx != state)  cnt_nx = '0;
    else if (cnt != CNT_SAT) cnt_nx = cnt + 1'b1;
    else                     cnt_nx = cnt;

    // A toggle clear always beats a completion flip
    if (bus.toggle_reset) toggle_nx = 1'b0;
    else if (flip)        toggle_nx = ~toggle_q;
    else                  toggle_nx = toggle_q;

    busy_nx = (state_nx != IDLE);
  end

  assign bus.TX_Packet   = tx_q;
  assign bus.hs_grant    = hs_grant_q;
  assign bus.data_grant  = data_grant_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.err_code    = err_code_q;
  assign bus.data_toggle = toggle_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_scheduler
// Purpose  : Directed self-checking bench for usb_tx_scheduler. Inputs change
//            and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_scheduler;
  logic clk;
  logic n_rst;
  int   total;
  int   bad;

  usb_tx_scheduler_if bus ();

  usb_tx_scheduler #(
    .IPG_CYCLES    (16),
    .START_TIMEOUT (8),
    .FILL_TIMEOUT  (255),
    .MAX_LEN       (64)
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop if the sequence ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Wait until the DUT returns to IDLE
  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 80) begin
      step();
      n++;
    end
    if (bus.busy) check(tag, 32'(bus.busy), 32'd0);
  endtask

  // Drive one USB_TX transfer; optional TX_Error pulse and toggle_reset on
  // the falling-activity cycle. Returns at the first GAP cycle.
  task automatic run_xfer(input int cycles, input logic with_err, input logic tog_rst);
    bus.TX_Transfer_Active = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      bus.TX_Error = (with_err && k == 2);
      step();
    end
    bus.TX_Error           = 1'b0;
    bus.TX_Transfer_Active = 1'b0;
    bus.toggle_reset       = tog_rst;
    step();
    bus.toggle_reset       = 1'b0;
  endtask

  initial begin
    int   n;
    logic seen;
    total = 0;
    bad   = 0;
    n_rst = 1'b0;
    bus.hs_req = 1'b0;  bus.hs_pid = 2'b00;
    bus.data_req = 1'b0; bus.data_len = 7'd0;
    bus.toggle_reset = 1'b0;
    bus.Buffer_Occupancy = 7'd0;
    bus.TX_Transfer_Active = 1'b0;
    bus.TX_Error = 1'b0;
    repeat (3) step();

    // Reset state
    check("rst_tx",     32'(bus.TX_Packet),   32'h0);
    check("rst_busy",   32'(bus.busy),        32'd0);
    check("rst_toggle", 32'(bus.data_toggle), 32'd0);
    check("rst_status", 32'({bus.done, bus.err, bus.err_code, bus.hs_grant, bus.data_grant}), 32'h0);
    n_rst = 1'b1;
    step();

    // STALL and data request together: handshake wins
    bus.hs_req = 1'b1; bus.hs_pid = 2'b10;
    bus.data_req = 1'b1; bus.data_len = 7'd8;
    step();
    check("stall_grant", 32'({bus.hs_grant, bus.data_grant}), 32'b10);
    check("stall_tx",    32'(bus.TX_Packet), 32'b1110);
    check("stall_busy",  32'(bus.busy), 32'd1);
    bus.hs_req = 1'b0;
    step();
    check("stall_tx_one", 32'(bus.TX_Packet), 32'h0);
    run_xfer(20, 1'b0, 1'b0);
    check("stall_done",   32'({bus.done, bus.err}), 32'b10);
    check("stall_toggle", 32'(bus.data_toggle), 32'd0);
    n = 0;
    while (!bus.data_grant && n < 40) begin
      step();
      n++;
    end
    check("gap_then_data_grant", 32'(n), 32'd17);
    bus.data_req = 1'b0;

    // Occupancy ramps 0 -> 8 over 30 cycles
    seen = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      bus.Buffer_Occupancy = 7'((i * 8) / 30);
      step();
      if (i < 30 && bus.TX_Packet != 4'h0) seen = 1'b1;
    end
    check("fill_no_early_tx", 32'(seen), 32'd0);
    check("data0_tx", 32'(bus.TX_Packet), 32'b0011);
    step();
    run_xfer(5, 1'b0, 1'b0);
    check("data0_done",   32'({bus.done, bus.err}), 32'b10);
    check("data0_toggle", 32'(bus.data_toggle), 32'd1);

    // Zero-length DATA1; completion coincides with toggle_reset
    bus.data_req = 1'b1; bus.data_len = 7'd0;
    n = 0;
    while (!bus.data_grant && n < 40) begin
      step();
      n++;
    end
    check("zlp_grant", 32'(bus.data_grant), 32'd1);
    bus.data_req = 1'b0;
    step();
    check("data1_tx", 32'(bus.TX_Packet), 32'b1011);
    step();
    run_xfer(4, 1'b0, 1'b1);
    check("data1_done",        32'(bus.done), 32'd1);
    check("toggle_reset_wins", 32'(bus.data_toggle), 32'd0);
    wait_idle("idle_a");

    // Over-length request rejected
    bus.data_req = 1'b1; bus.data_len = 7'd70;
    step();
    check("len70_grant_err", 32'({bus.data_grant, bus.err, bus.err_code}), 32'b1101);
    check("len70_tx",        32'(bus.TX_Packet), 32'h0);
    bus.data_req = 1'b0;
    step();
    check("len70_idle", 32'({bus.busy, bus.err, bus.TX_Packet}), 32'h0);

    // Fill timeout: length 4, occupancy stuck at 2
    bus.Buffer_Occupancy = 7'd2;
    bus.data_req = 1'b1; bus.data_len = 7'd4;
    step();
    check("fill_grant", 32'(bus.data_grant), 32'd1);
    bus.data_req = 1'b0;
    n = 0; seen = 1'b0;
    while (!bus.err && n < 300) begin
      step();
      n++;
      if (bus.TX_Packet != 4'h0) seen = 1'b1;
    end
    check("fill_timeout_cycles", 32'(n), 32'd255);
    check("fill_timeout_code",   32'(bus.err_code), 32'b10);
    check("fill_timeout_no_tx",  32'(seen), 32'd0);
    step();

    // Start timeout: ACK issued, TX_Transfer_Active never rises
    bus.hs_req = 1'b1; bus.hs_pid = 2'b00;
    step();
    check("ack_tx", 32'(bus.TX_Packet), 32'b0010);
    bus.hs_req = 1'b0;
    n = 0;
    while (!bus.err && n < 40) begin
      step();
      n++;
    end
    check("start_timeout_cycles", 32'(n), 32'd9);
    check("start_timeout_code",   32'({bus.err_code, bus.done}), 32'b110);
    wait_idle("idle_b");

    // TX_Error during a DATA0 transfer
    bus.data_req = 1'b1; bus.data_len = 7'd0;
    step();
    bus.data_req = 1'b0;
    step();
    check("err_data_tx", 32'(bus.TX_Packet), 32'b0011);
    run_xfer(5, 1'b1, 1'b0);
    check("txerr_err",    32'({bus.err, bus.done, bus.err_code}), 32'b1000);
    check("txerr_toggle", 32'(bus.data_toggle), 32'd0);
    wait_idle("idle_c");

    // Successful DATA0 so the toggle is 1 before the reset test
    bus.data_req = 1'b1;
    step();
    bus.data_req = 1'b0;
    step();
    check("pre_rst_tx", 32'(bus.TX_Packet), 32'b0011);
    run_xfer(3, 1'b0, 1'b0);
    check("pre_rst_toggle", 32'(bus.data_toggle), 32'd1);
    wait_idle("idle_d");

    // Reset held two cycles during ACTIVE of a NAK
    bus.hs_req = 1'b1; bus.hs_pid = 2'b01;
    step();
    check("nak_tx", 32'(bus.TX_Packet), 32'b1010);
    bus.hs_req = 1'b0;
    bus.TX_Transfer_Active = 1'b1;
    repeat (3) step();
    n_rst = 1'b0;
    step();
    check("midrst_state", 32'({bus.TX_Packet, bus.busy, bus.data_toggle}), 32'h0);
    step();
    n_rst = 1'b1;
    bus.TX_Transfer_Active = 1'b0;
    step();
    bus.hs_req = 1'b1; bus.hs_pid = 2'b00;
    step();
    check("post_rst_grant", 32'({bus.hs_grant, bus.TX_Packet}), 32'b10010);
    bus.hs_req = 1'b0;
    step();
    run_xfer(3, 1'b0, 1'b0);
    check("post_rst_done", 32'(bus.done), 32'd1);
    wait_idle("idle_e");

    // Reserved handshake PID rejected
    bus.hs_req = 1'b1; bus.hs_pid = 2'b11;
    step();
    check("pid11_err", 32'({bus.hs_grant, bus.err, bus.err_code}), 32'b1101);
    check("pid11_tx",  32'(bus.TX_Packet), 32'h0);
    bus.hs_req = 1'b0;
    step();
    check("pid11_idle", 32'({bus.busy, bus.TX_Packet}), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
